// File: rtl/counter_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl_if
// Brief    : Signal bundle between the sequencing controller and the
//            button / counter / display path around it.
// Revision : 1.0  initial release
// ============================================================================
interface counter_seq_ctrl_if;
    logic       inc;        // debounced button level
    logic       set;        // debounced button level
    logic       dir;        // 0 = count up to preset, 1 = count down to 0
    logic [7:0] count_q;    // live counter value
    logic       up;
    logic       enable;
    logic       load;
    logic [7:0] load_data;
    logic [7:0] disp;
    logic [1:0] blank;
    logic       done;
    logic [2:0] state;

    // Controller side
    modport master (
        input  inc, set, dir, count_q,
        output up, enable, load, load_data, disp, blank, done, state
    );

    // Button / counter / display side
    modport slave (
        output inc, set, dir, count_q,
        input  up, enable, load, load_data, disp, blank, done, state
    );
endinterface
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Brief    : Preset-entry / run / pause / done sequencer driving an 8-bit
//            up/down counter plus seven-segment display select and blink.
// Revision : 1.0  initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int TICK_DIV  = 4,    // clk cycles per counter step in RUN
    parameter int BLINK_DIV = 8     // clk cycles per blink half-period
) (
    input  wire logic          clk,
    input  wire logic          clr,
    counter_seq_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SET_HI = 3'd1;
    localparam logic [2:0] S_SET_LO = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] c_TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] c_BLINK_MAX = BW'(BLINK_DIV - 1);

    logic          inc_q, set_q;
    logic [2:0]    state_q, state_d;
    logic [7:0]    preset_q, preset_d;
    logic          dir_l_q, dir_l_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          enable_q, enable_d;
    logic          load_q, load_d;
    logic          up_q, up_d;
    logic          done_q, done_d;
    logic [1:0]    blank_q, blank_d;

    logic          w_set_p;
    logic          w_inc_p;
    logic [7:0]    w_target;
    logic          w_in_set_d;

    // set wins when both buttons rise together; inc is then discarded
    assign w_set_p  = bus.set & ~set_q;
    assign w_inc_p  = bus.inc & ~inc_q & ~w_set_p;
    assign w_target = dir_l_q ? 8'h00 : preset_q;

    // Sequencing: state, preset editing, run tick and one-cycle strobes
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        dir_l_d  = dir_l_q;
        tick_d   = tick_q;
        enable_d = 1'b0;
        load_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_set_p) begin
                    state_d = S_SET_HI;
                end else if (w_inc_p) begin
                    state_d = S_RUN;
                    dir_l_d = bus.dir;
                    tick_d  = '0;
                end
            end
            S_SET_HI: begin
                if (w_set_p) begin
                    state_d = S_SET_LO;
                end else if (w_inc_p) begin
                    preset_d[7:4] = preset_q[7:4] + 4'd1;
                end
            end
            S_SET_LO: begin
                if (w_set_p) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (w_inc_p) begin
                    preset_d[3:0] = preset_q[3:0] + 4'd1;
                end
            end
            S_RUN: begin
                if (w_set_p) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (w_inc_p) begin
                    state_d = S_PAUSE;          // tick frozen for resume
                end else if (tick_q == c_TICK_MAX) begin
                    tick_d = '0;
                    if (bus.count_q == w_target) begin
                        state_d = S_DONE;
                    end else begin
                        enable_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_PAUSE: begin
                if (w_set_p) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (w_inc_p) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (w_set_p || w_inc_p) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Blink timing restarts on every entry into a preset-edit state
    always_comb begin
        w_in_set_d = (state_d == S_SET_HI) || (state_d == S_SET_LO);
        blink_d    = '0;
        phase_d    = 1'b0;
        if (w_in_set_d && (state_d == state_q)) begin
            if (blink_q == c_BLINK_MAX) begin
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
                phase_d = phase_q;
            end
        end
    end

    // Registered outputs are computed from next-state so they align with state
    always_comb begin
        up_d    = ((state_d == S_RUN) || (state_d == S_PAUSE) ||
                   (state_d == S_DONE)) & ~dir_l_d;
        done_d  = (state_d == S_DONE);
        blank_d = 2'b00;
        if (state_d == S_SET_HI) begin
            blank_d = {phase_d, 1'b0};
        end else if (state_d == S_SET_LO) begin
            blank_d = {1'b0, phase_d};
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            inc_q    <= 1'b0;
            set_q    <= 1'b0;
            state_q  <= S_IDLE;
            preset_q <= 8'h00;
            dir_l_q  <= 1'b0;
            tick_q   <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            enable_q <= 1'b0;
            load_q   <= 1'b0;
            up_q     <= 1'b0;
            done_q   <= 1'b0;
            blank_q  <= 2'b00;
        end else begin
            inc_q    <= bus.inc;
            set_q    <= bus.set;
            state_q  <= state_d;
            preset_q <= preset_d;
            dir_l_q  <= dir_l_d;
            tick_q   <= tick_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            enable_q <= enable_d;
            load_q   <= load_d;
            up_q     <= up_d;
            done_q   <= done_d;
            blank_q  <= blank_d;
        end
    end

    assign bus.up        = up_q;
    assign bus.enable    = enable_q;
    assign bus.load      = load_q;
    assign bus.done      = done_q;
    assign bus.blank     = blank_q;
    assign bus.state     = state_q;
    assign bus.load_data = bus.dir ? preset_q : 8'h00;
    assign bus.disp      = ((state_q == S_SET_HI) || (state_q == S_SET_LO)) ?
                           preset_q : bus.count_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Brief    : Self-checking bench for counter_seq_ctrl with a counter model
//            and a behavioural reference of the button sequencing.
// Revision : 1.0  initial release
// ============================================================================
module tb_counter_seq_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] cnt;

    always #5 clk = ~clk;

    counter_seq_ctrl_if bus ();

    counter_seq_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Counter datapath emulation
    assign bus.count_q = cnt;
    always @(posedge clk or posedge clr) begin
        if (clr)             cnt <= 8'h00;
        else if (bus.load)   cnt <= bus.load_data;
        else if (bus.enable) cnt <= bus.up ? cnt + 8'd1 : cnt - 8'd1;
    end

    int total = 0;
    int bad   = 0;

    // Reference model of the sequencer
    int m_state, m_preset, m_dirl, m_run, m_blk, n_en;
    bit m_incq, m_setq, m_en, m_ld;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_preset = 0; m_dirl = 0; m_run = 0; m_blk = 0;
        m_incq = 0;  m_setq = 0;   m_en = 0;   m_ld = 0;
    endtask

    task automatic compare_all();
        int  ph;
        logic [1:0] exp_blank;
        ph = (m_blk / BLINK_DIV) % 2;
        exp_blank = (m_state == 1) ? {ph[0], 1'b0} :
                    (m_state == 2) ? {1'b0, ph[0]} : 2'b00;
        check_val("state",  32'(bus.state),  32'(m_state));
        check_val("enable", 32'(bus.enable), 32'(m_en));
        check_val("load",   32'(bus.load),   32'(m_ld));
        check_val("up",     32'(bus.up),
                  32'(((m_state >= 3) && (m_state <= 5) && (m_dirl == 0)) ? 1 : 0));
        check_val("done",   32'(bus.done),   32'(m_state == 5));
        check_val("blank",  32'(bus.blank),  32'(exp_blank));
        check_val("disp",   32'(bus.disp),
                  32'((m_state == 1 || m_state == 2) ? m_preset : int'(cnt)));
        check_val("load_data", 32'(bus.load_data), 32'(bus.dir ? m_preset : 0));
    endtask

    // One clock with the given button/dir levels, model update and compare
    task automatic cycle(input bit inc, input bit set, input bit dir);
        int c0, prev;
        bit ip, sp;
        @(negedge clk);
        bus.inc = inc; bus.set = set; bus.dir = dir;
        c0 = int'(cnt);
        @(posedge clk);
        sp = set && !m_setq;
        ip = inc && !m_incq && !sp;
        m_incq = inc; m_setq = set; m_en = 0; m_ld = 0;
        prev = m_state;
        case (m_state)
            0: if (sp) m_state = 1;
               else if (ip) begin m_state = 3; m_dirl = dir; m_run = 0; end
            1: if (sp) m_state = 2;
               else if (ip) m_preset = (m_preset + 16) % 256;
            2: if (sp) begin m_state = 0; m_ld = 1; end
               else if (ip) m_preset = (m_preset & 8'hF0) | ((m_preset + 1) % 16);
            3: if (sp) begin m_state = 0; m_ld = 1; end
               else if (ip) m_state = 4;
               else begin
                   m_run++;
                   if (m_run % TICK_DIV == 0) begin
                       if (c0 == (m_dirl ? 0 : m_preset)) m_state = 5;
                       else begin m_en = 1; n_en++; end
                   end
               end
            4: if (sp) begin m_state = 0; m_ld = 1; end
               else if (ip) m_state = 3;
            default: if (sp || ip) begin m_state = 0; m_ld = 1; end
        endcase
        if (m_state == 1 || m_state == 2) begin
            if (m_state != prev) m_blk = 0;
            else m_blk++;
        end
        #1;
        compare_all();
    endtask

    task automatic press(input bit inc, input bit set, input bit dir);
        cycle(inc, set, dir);
        cycle(0, 0, dir);
    endtask

    task automatic idle(input int n, input bit dir);
        for (int i = 0; i < n; i++) cycle(0, 0, dir);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic async_reset();
        @(negedge clk);
        bus.inc = 0; bus.set = 0;
        #2 clr = 1'b1;
        #1;
        model_reset();
        check_val("rst_state",  32'(bus.state),  32'd0);
        check_val("rst_enable", 32'(bus.enable), 32'd0);
        check_val("rst_load",   32'(bus.load),   32'd0);
        check_val("rst_up",     32'(bus.up),     32'd0);
        check_val("rst_done",   32'(bus.done),   32'd0);
        check_val("rst_blank",  32'(bus.blank),  32'd0);
        check_val("rst_ldata",  32'(bus.load_data), 32'd0);
        @(negedge clk);
        #2 clr = 1'b0;
    endtask

    task automatic run_to_done(input bit dir);
        int k;
        k = 0;
        while (m_state != 5 && k < 200) begin
            cycle(0, 0, dir);
            k++;
        end
        check_val("done_reached", 32'(m_state == 5), 32'd1);
    endtask

    int saved;

    initial begin
        bus.inc = 0; bus.set = 0; bus.dir = 0;
        clr = 1'b1;
        model_reset();
        n_en = 0;
        #12;
        check_val("init_state", 32'(bus.state),  32'd0);
        check_val("init_disp",  32'(bus.disp),   32'(cnt));
        @(negedge clk);
        clr = 1'b0;

        // Preset entry: 0x30 then 0x3A, load 0 on exit with dir=0
        press(0, 1, 0);
        for (int i = 0; i < 3; i++) press(1, 0, 0);
        check_val("edit_hi", 32'(bus.disp), 32'h30);
        press(0, 1, 0);
        for (int i = 0; i < 10; i++) press(1, 0, 0);
        check_val("edit_lo", 32'(bus.disp), 32'h3A);
        cycle(0, 1, 0);
        check_val("exit_load", 32'(bus.load), 32'd1);
        check_val("exit_ldata", 32'(bus.load_data), 32'h00);
        cycle(0, 0, 0);

        // Preset 0x05, count up
        press(0, 1, 0);
        for (int i = 0; i < 13; i++) press(1, 0, 0);
        press(0, 1, 0);
        for (int i = 0; i < 11; i++) press(1, 0, 0);
        press(0, 1, 0);
        n_en = 0;
        press(1, 0, 0);
        run_to_done(0);
        check_val("up_strobes", 32'(n_en), 32'd5);
        check_val("up_final",   32'(cnt),  32'h05);
        press(1, 0, 0);

        // Preset 0x03, count down
        press(0, 1, 1);
        press(0, 1, 1);
        for (int i = 0; i < 14; i++) press(1, 0, 1);
        cycle(0, 1, 1);
        check_val("dn_ldata", 32'(bus.load_data), 32'h03);
        cycle(0, 0, 1);
        check_val("dn_loaded", 32'(cnt), 32'h03);
        n_en = 0;
        press(1, 0, 1);
        run_to_done(1);
        check_val("dn_strobes", 32'(n_en), 32'd3);
        check_val("dn_final",   32'(cnt),  32'h00);

        // Pause / resume / abort
        press(0, 1, 1);
        press(1, 0, 1);
        idle(4, 1);
        press(1, 0, 1);
        saved = n_en;
        idle(20, 1);
        check_val("pause_hold", 32'(n_en), 32'(saved));
        press(1, 0, 1);
        idle(2 * TICK_DIV, 1);
        check_val("resume", 32'(n_en > saved), 32'd1);
        press(0, 1, 1);

        // Simultaneous rise, held button, nibble wrap
        saved = m_preset;
        cycle(1, 1, 0);
        check_val("simul_state", 32'(bus.state), 32'd1);
        check_val("simul_preset", 32'(bus.disp), 32'(saved));
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < 50; i++) cycle(1, 0, 0);
        cycle(0, 0, 0);
        check_val("held_once", 32'(bus.disp), 32'((saved + 16) % 256));
        saved = m_preset;
        for (int i = 0; i < 16; i++) press(1, 0, 0);
        check_val("wrap16", 32'(bus.disp), 32'(saved));
        press(0, 1, 0);
        press(0, 1, 0);

        // Async reset mid-RUN, then no enable without a new inc
        press(1, 0, 0);
        idle(5, 0);
        async_reset();
        n_en = 0;
        idle(20, 0);
        check_val("post_rst_quiet", 32'(n_en), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 5) == 0, ($urandom % 11) == 0, $urandom % 2);
            if (($urandom % 500) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller for the 8-bit up/down counter datapath in the counter FSM design. It turns the debounced `inc`/`set` buttons into a preset-entry / run / pause / done sequence. It drives the counter's `up`, `enable` and a synchronous load, and selects what the seven-segment path displays (preset or live count) together with per-nibble blink blanking. It sits between the debounce instances and the counter/mux4x1 path, and replaces the free-running FSM.

## Interface
- `TICK_DIV`, 4: clk cycles per counter step in RUN (≥2).
- `BLINK_DIV`, 8: clk cycles per blink half-period in SET states (≥1).

- `clk`  in  1  clock; all logic on rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `inc`  in  1  debounced button level; rising edge used.
- `set`  in  1  debounced button level; rising edge used.
- `dir`  in  1  level; 0 = count up to preset, 1 = count down from preset to 0.
- `count_q`  in  8  current counter value.
- `up`  out  1  counter direction.
- `enable`  out  1  one-cycle count strobe.
- `load`  out  1  one-cycle synchronous load strobe.
- `load_data`  out  8  value to load.
- `disp`  out  8  value to display.
- `blank`  out  2  `[1]` blanks high nibble, `[0]` blanks low nibble.
- `done`  out  1  target reached.
- `state`  out  3  state encoding, for LEDs.

## Operation
- Edge detect: registers `inc_q` and `set_q`. Derived pulses are `inc_p = inc & ~inc_q` and `set_p = set & ~set_q`.
- Priority: if `set_p` and `inc_p` occur in the same cycle, `set_p` wins and `inc_p` is dropped.
- Registers: `preset[7:0]`, `dir_l` (latched `dir`), `tick` (0..TICK_DIV-1) and blink counter/phase.
- Target: `target = dir_l ? 8'h00 : preset`. Load value: `load_data = dir ? preset : 8'h00`, using live `dir`.
- States (`state` encoding):
  - IDLE=0
    - `set_p` → SET_HI.
    - `inc_p` → RUN, latch `dir_l = dir`, `tick = 0`.
  - SET_HI=1
    - `inc_p`: `preset[7:4] += 1`, wrapping F→0.
    - `set_p` → SET_LO.
  - SET_LO=2
    - `inc_p`: `preset[3:0] += 1`, wrapping F→0.
    - `set_p` → IDLE, pulse `load`.
  - RUN=3
    - `tick` increments each cycle. At `tick == TICK_DIV-1`, `tick` wraps to 0 and:
      - if `count_q == target` → DONE, no `enable`;
      - else pulse `enable`.
    - `inc_p` → PAUSE, `tick` held.
    - `set_p` → IDLE, pulse `load` (abort and reload).
  - PAUSE=4
    - `inc_p` → RUN, `tick` resumes from its held value.
    - `set_p` → IDLE, pulse `load`.
  - DONE=5
    - `done = 1`.
    - `inc_p` or `set_p` → IDLE, pulse `load`.
  - Codes 6/7 → IDLE on next edge.
- Output mapping:
  - `up = ~dir_l` in RUN/PAUSE/DONE, else 0.
  - `disp = preset` in SET_HI/SET_LO, else `count_q`.
  - `blank`:
    - SET_HI: `blank = {phase, 0}`.
    - SET_LO: `blank = {0, phase}`.
    - other states: `blank = 2'b00`.
    - `phase` toggles every BLINK_DIV cycles. Blink counter and `phase` are cleared on entry to SET_HI and SET_LO.
- Preset editing changes only `preset`, never the counter. The counter changes only via the `load` strobe at SET_LO exit or abort.

## Timing
- Reset (`clr` high, asynchronous):
  - state IDLE, `preset = 0`, `dir_l = 0`, `tick = 0`, `phase = 0`, `inc_q = set_q = 0`.
  - Outputs: `up = enable = load = done = 0`, `blank = 0`, `state = 0`, `disp = count_q`, `load_data = dir ? preset : 0` (i.e. 0).
  - Reset mid-RUN takes effect immediately, with no trailing `enable`.
- `enable`, `load`, `up`, `done`, `state`, `blank` are registered. `disp` and `load_data` are combinational from registers and inputs.
- Button to state: a rising `inc`/`set` sampled at edge n changes `state` after edge n. Its `load` pulse is high for exactly the cycle after edge n.
- A held button produces one pulse only. A new pulse requires the button to be low for at least one sampled cycle.
- `enable` is high for exactly 1 cycle per TICK_DIV cycles in RUN. The first strobe comes TICK_DIV cycles after entering RUN from IDLE.
- The DONE decision uses `count_q` sampled at the tick. Because the counter updates on the edge after `enable`, the final count is displayed before DONE is entered.
- Preset = 0 with `dir = 0` gives immediate DONE at the first tick, with no `enable`.

## Test plan
- Reset then edit: pulse `set`, `inc`×3, `set`, `inc`×0x0A, `set`.
  - During edits, `state` steps 1→2; `disp` shows 0x30, then 0x3A.
  - SET_LO exit: `load = 1` for 1 cycle with `load_data = 0x00` (`dir = 0`).
- Count up: preset 0x05, `dir = 0`, pulse `inc`.
  - Exactly 5 `enable` strobes, each TICK_DIV apart, `up = 1`.
  - With the counter model, `count_q` reaches 0x05, then `done = 1`, `state = 5`.
- Count down: preset 0x03, `dir = 1`.
  - SET_LO exit loads 0x03.
  - RUN gives 3 strobes with `up = 0`, then DONE at `count_q = 0`.
- Pause/abort: in RUN, pulse `inc`.
  - PAUSE holds with no `enable` for 20 cycles.
  - Pulse `inc` again: strobes resume.
  - Pulse `set`: IDLE, `load` pulse.
- Simultaneous `inc`/`set` rise in IDLE → SET_HI; preset unchanged.
  - Holding `inc` high for 50 cycles in SET_HI increments `preset[7:4]` once only.
  - 16 pulses wrap the nibble back to its start value.
- Async `clr` mid-RUN between clock edges: outputs reach reset values without waiting for a clock edge.
  - After release, no `enable` until a new `inc` pulse.
  - `blank` toggles every BLINK_DIV cycles in SET_HI.
